// File: rtl/move_rx_parser.sv
// ---------------------------------------------------------------------------
// move_rx_parser
//   Parses newline-terminated ASCII frames arriving one byte per strobe from a
//   UART receiver into either a board move or a player colour.
//
//   Frames:
//     colour : "-W" | "-B", optional CRs, LF
//     move   : ('@' | 'A'..'Z'+) digit+ tile, optional CRs, LF
//              tile '+' -> 0, '/' -> 1, '\' -> 2
//              column letters are bijective base-26 ('A'=1 .. 'Z'=26, "AA"=27)
//
//   Ports:
//     clock        rising-edge clock
//     reset        asynchronous, active-low reset
//     rx_data[7:0] received byte, qualified by rx_valid
//     rx_valid     one-cycle byte strobe
//     move_out     {tile[1:0], row[9:0], col[9:0]}, held between frames
//     move_valid   one-cycle pulse, move_out just updated
//     color        0 = white, 1 = black, held between frames
//     color_valid  one-cycle pulse, color just updated
//     frame_err    one-cycle pulse on the first rejected byte of a frame
//
//   All three pulses are registered, so they appear exactly one cycle after
//   the strobe that produced them and are mutually exclusive by construction.
// ---------------------------------------------------------------------------
module move_rx_parser (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [21:0] move_out,
    output logic        move_valid,
    output logic        color,
    output logic        color_valid,
    output logic        frame_err
);

    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_DASH  = 8'h2D;
    localparam logic [7:0] CH_AT    = 8'h40;
    localparam logic [7:0] CH_PLUS  = 8'h2B;
    localparam logic [7:0] CH_SLASH = 8'h2F;
    localparam logic [7:0] CH_BSL   = 8'h5C;
    localparam logic [7:0] CH_W     = 8'h57;
    localparam logic [7:0] CH_B     = 8'h42;

    localparam logic [14:0] COORD_MAX = 15'd1023;

    typedef enum logic [2:0] {
        IDLE,
        COLOR,
        COL,
        ROW,
        TILE,
        EOL,
        DISCARD
    } state_t;

    state_t      state_q,       state_d;
    logic [14:0] col_q,         col_d;
    logic [14:0] row_q,         row_d;
    logic        have_digit_q,  have_digit_d;
    logic [1:0]  tile_q,        tile_d;
    logic        color_pend_q,  color_pend_d;
    logic        is_color_q,    is_color_d;
    logic [21:0] move_out_q,    move_out_d;
    logic        color_q,       color_d;
    logic        move_valid_q,  move_valid_d;
    logic        color_valid_q, color_valid_d;
    logic        frame_err_q,   frame_err_d;

    logic        is_upper;
    logic        is_digit;
    logic [14:0] col_mac;
    logic [14:0] row_mac;
    logic        reject;

    assign is_upper = (rx_data >= 8'h41) && (rx_data <= 8'h5A);
    assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);

    // 15-bit accumulators: with the stored value capped at 1023 the largest
    // intermediate is 1023*26+26, so the range check sees the true value.
    // For 'A'..'Z', code-0x40 is simply the low five bits.
    assign col_mac = (col_q * 15'd26) + {10'd0, rx_data[4:0]};
    assign row_mac = (row_q * 15'd10) + {11'd0, rx_data[3:0]};

    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        row_d         = row_q;
        have_digit_d  = have_digit_q;
        tile_d        = tile_q;
        color_pend_d  = color_pend_q;
        is_color_d    = is_color_q;
        move_out_d    = move_out_q;
        color_d       = color_q;
        move_valid_d  = 1'b0;
        color_valid_d = 1'b0;
        frame_err_d   = 1'b0;
        reject        = 1'b0;

        if (rx_valid) begin
            case (state_q)
                IDLE: begin
                    if (rx_data == CH_DASH) begin
                        state_d = COLOR;
                    end else if (rx_data == CH_AT) begin
                        col_d        = '0;
                        row_d        = '0;
                        have_digit_d = 1'b0;
                        state_d      = ROW;
                    end else if (is_upper) begin
                        col_d        = {10'd0, rx_data[4:0]};
                        row_d        = '0;
                        have_digit_d = 1'b0;
                        state_d      = COL;
                    end else if ((rx_data == CH_LF) || (rx_data == CH_CR)) begin
                        state_d = IDLE;
                    end else begin
                        reject = 1'b1;
                    end
                end

                COLOR: begin
                    if (rx_data == CH_W || rx_data == CH_B) begin
                        color_pend_d = (rx_data == CH_B);
                        is_color_d   = 1'b1;
                        state_d      = EOL;
                    end else begin
                        reject = 1'b1;
                    end
                end

                COL: begin
                    if (is_upper) begin
                        if (col_mac > COORD_MAX) reject = 1'b1;
                        else                     col_d  = col_mac;
                    end else if (is_digit) begin
                        row_d        = {11'd0, rx_data[3:0]};
                        have_digit_d = 1'b1;
                        state_d      = ROW;
                    end else begin
                        reject = 1'b1;
                    end
                end

                ROW: begin
                    if (is_digit) begin
                        if (row_mac > COORD_MAX) begin
                            reject = 1'b1;
                        end else begin
                            row_d        = row_mac;
                            have_digit_d = 1'b1;
                        end
                    end else if ((rx_data == CH_PLUS) || (rx_data == CH_SLASH) ||
                                 (rx_data == CH_BSL)) begin
                        if (!have_digit_q) begin
                            reject = 1'b1;
                        end else begin
                            tile_d     = (rx_data == CH_PLUS)  ? 2'd0 :
                                         (rx_data == CH_SLASH) ? 2'd1 : 2'd2;
                            is_color_d = 1'b0;
                            state_d    = EOL;
                        end
                    end else begin
                        reject = 1'b1;
                    end
                end

                EOL: begin
                    if (rx_data == CH_LF) begin
                        state_d = IDLE;
                        if (is_color_q) begin
                            color_d       = color_pend_q;
                            color_valid_d = 1'b1;
                        end else begin
                            move_out_d   = {tile_q, row_q[9:0], col_q[9:0]};
                            move_valid_d = 1'b1;
                        end
                    end else if (rx_data != CH_CR) begin
                        reject = 1'b1;
                    end
                end

                DISCARD: begin
                    if (rx_data == CH_LF) state_d = IDLE;
                end

                // The tile character is consumed directly in ROW, so TILE is
                // never entered; if it ever is, treat the frame as corrupt.
                TILE:    reject  = 1'b1;
                default: state_d = IDLE;
            endcase
        end

        // A rejected byte pulses frame_err once. If the offending byte is the
        // terminating LF itself the frame is already over, so return straight
        // to IDLE rather than swallowing the following frame.
        if (reject) begin
            frame_err_d = 1'b1;
            state_d     = (rx_data == CH_LF) ? IDLE : DISCARD;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            col_q         <= '0;
            row_q         <= '0;
            have_digit_q  <= 1'b0;
            tile_q        <= '0;
            color_pend_q  <= 1'b0;
            is_color_q    <= 1'b0;
            move_out_q    <= '0;
            color_q       <= 1'b0;
            move_valid_q  <= 1'b0;
            color_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            row_q         <= row_d;
            have_digit_q  <= have_digit_d;
            tile_q        <= tile_d;
            color_pend_q  <= color_pend_d;
            is_color_q    <= is_color_d;
            move_out_q    <= move_out_d;
            color_q       <= color_d;
            move_valid_q  <= move_valid_d;
            color_valid_q <= color_valid_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign move_out    = move_out_q;
    assign move_valid  = move_valid_q;
    assign color       = color_q;
    assign color_valid = color_valid_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_move_rx_parser.sv
// ---------------------------------------------------------------------------
// tb_move_rx_parser
//   Directed frames followed by randomized frame streams. The reference model
//   buffers the bytes of the current frame and re-parses the whole buffer on
//   every byte to decide whether it is still a legal prefix, a complete
//   frame, or broken.
// ---------------------------------------------------------------------------
module tb_move_rx_parser;

    localparam int PARTIAL = 0;
    localparam int BAD     = 1;
    localparam int MOVE    = 2;
    localparam int COLR    = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [21:0] move_out;
    logic        move_valid;
    logic        color;
    logic        color_valid;
    logic        frame_err;

    move_rx_parser dut (
        .clock       (clock),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .move_out    (move_out),
        .move_valid  (move_valid),
        .color       (color),
        .color_valid (color_valid),
        .frame_err   (frame_err)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    int mv_count = 0;
    int cv_count = 0;
    int fe_count = 0;

    // reference model state
    logic [7:0]  fbuf[$];
    bit          discarding = 0;
    logic [21:0] exp_move   = '0;
    logic        exp_color  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_up(input logic [7:0] c);
        return (c >= 8'h41) && (c <= 8'h5A);
    endfunction

    function automatic bit is_dig(input logic [7:0] c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

    // Classify a frame buffer (leading CR/LF already stripped).
    function automatic int classify(input logic [7:0] b[$], output logic [21:0] mv,
                                    output logic c);
        int n, i, col, row, nd, kind;
        logic [1:0] t;
        n = b.size(); i = 0; mv = '0; c = 1'b0; kind = MOVE;
        if (b[0] == "-") begin
            if (n < 2) return PARTIAL;
            if (b[1] != "W" && b[1] != "B") return BAD;
            c = (b[1] == "B");
            kind = COLR;
            i = 2;
        end else begin
            col = 0;
            if (b[0] == "@") i = 1;
            else begin
                while (i < n && is_up(b[i])) begin
                    col = col * 26 + int'(b[i]) - 64;
                    if (col > 1023) return BAD;
                    i++;
                end
                if (i == 0) return BAD;
            end
            if (i == n) return PARTIAL;
            row = 0; nd = 0;
            while (i < n && is_dig(b[i])) begin
                row = row * 10 + int'(b[i]) - 48;
                if (row > 1023) return BAD;
                i++; nd++;
            end
            if (i == n) return PARTIAL;
            if (nd == 0) return BAD;
            if      (b[i] == "+")  t = 2'd0;
            else if (b[i] == "/")  t = 2'd1;
            else if (b[i] == "\\") t = 2'd2;
            else return BAD;
            i++;
            mv = {t, 10'(row), 10'(col)};
        end
        while (i < n) begin
            if (b[i] == 8'h0D) i++;
            else if (b[i] == 8'h0A && i == n - 1) return kind;
            else return BAD;
        end
        return PARTIAL;
    endfunction

    // One clock: drive (v,d), advance the model, check all outputs after the edge.
    task automatic step(input bit v, input logic [7:0] d);
        logic e_mv, e_cv, e_fe, c;
        logic [21:0] mv;
        int r;
        e_mv = 0; e_cv = 0; e_fe = 0;
        rx_valid = v;
        rx_data  = d;
        if (v) begin
            if (discarding) begin
                if (d == 8'h0A) discarding = 0;
            end else if (fbuf.size() == 0 && (d == 8'h0A || d == 8'h0D)) begin
                // inter-frame line endings are ignored
            end else begin
                fbuf.push_back(d);
                r = classify(fbuf, mv, c);
                if (r == BAD) begin
                    e_fe = 1; discarding = (d != 8'h0A); fbuf.delete();
                end else if (r == MOVE) begin
                    e_mv = 1; exp_move = mv; fbuf.delete();
                end else if (r == COLR) begin
                    e_cv = 1; exp_color = c; fbuf.delete();
                end
            end
        end
        @(posedge clock);
        #1;
        rx_valid = 1'b0;
        if (move_valid === 1'b1)  mv_count++;
        if (color_valid === 1'b1) cv_count++;
        if (frame_err === 1'b1)   fe_count++;
        chk("move_valid",  32'(move_valid),  32'(e_mv));
        chk("color_valid", 32'(color_valid), 32'(e_cv));
        chk("frame_err",   32'(frame_err),   32'(e_fe));
        chk("move_out",    32'(move_out),    32'(exp_move));
        chk("color",       32'(color),       32'(exp_color));
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) step(1'b1, s[i]);
    endtask

    task automatic clr_counts();
        mv_count = 0; cv_count = 0; fe_count = 0;
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        reset = 1'b0;
        #1;
        fbuf.delete(); discarding = 0; exp_move = '0; exp_color = 1'b0;
        chk("rst_move_out",    32'(move_out),    32'd0);
        chk("rst_color",       32'(color),       32'd0);
        chk("rst_move_valid",  32'(move_valid),  32'd0);
        chk("rst_color_valid", 32'(color_valid), 32'd0);
        chk("rst_frame_err",   32'(frame_err),   32'd0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    // bijective base-26 column letters
    task automatic push_col(inout logic [7:0] q[$], input int col);
        logic [7:0] tmp[$];
        int c;
        c = col;
        while (c > 0) begin
            c = c - 1;
            tmp.push_front(8'(65 + c % 26));
            c = c / 26;
        end
        foreach (tmp[k]) q.push_back(tmp[k]);
    endtask

    task automatic push_row(inout logic [7:0] q[$], input int row);
        logic [7:0] tmp[$];
        int r;
        r = row;
        if (r == 0) tmp.push_back("0");
        while (r > 0) begin
            tmp.push_front(8'(48 + r % 10));
            r = r / 10;
        end
        foreach (tmp[k]) q.push_back(tmp[k]);
    endtask

    task automatic gen_move(inout logic [7:0] q[$]);
        logic [7:0] tiles[3];
        tiles[0] = "+"; tiles[1] = "/"; tiles[2] = "\\";
        if ($urandom_range(0, 3) == 0) q.push_back("@");
        else push_col(q, int'($urandom_range(1, 1023)));
        if ($urandom_range(0, 7) == 0) push_row(q, int'($urandom_range(1000, 1100)));
        else push_row(q, int'($urandom_range(0, 999)));
        q.push_back(tiles[$urandom_range(0, 2)]);
        if ($urandom_range(0, 4) == 0) q.push_back(8'h0D);
        q.push_back(8'h0A);
    endtask

    initial begin
        logic [7:0] q[$];
        int kind, pos;

        #2;
        do_reset();

        // colour frame
        clr_counts();
        send_str("-B\n");
        chk("dir_black_cv", 32'(color_valid), 32'd1);
        chk("dir_black",    32'(color),       32'd1);

        // '@' column, tile '/'
        send_str("@0/\n");
        chk("dir_at_mv",  32'(move_valid), 32'd1);
        chk("dir_at_out", 32'(move_out),   32'({2'd1, 10'd0, 10'd0}));

        // two-letter column, backslash tile, CR before LF
        send_str("AB12\\\r\n");
        chk("dir_ab_mv",  32'(move_valid), 32'd1);
        chk("dir_ab_out", 32'(move_out),   32'({2'd2, 10'd12, 10'd28}));

        // rejected frame followed by a good one, back to back
        clr_counts();
        send_str("A1X\nB3+\n");
        chk("dir_err_cnt", 32'(fe_count),  32'd1);
        chk("dir_err_mv",  32'(mv_count),  32'd1);
        chk("dir_err_out", 32'(move_out),  32'({2'd0, 10'd3, 10'd2}));

        // row overflow
        clr_counts();
        send_str("A1024+\n");
        chk("dir_ovf_fe", 32'(fe_count), 32'd1);
        chk("dir_ovf_mv", 32'(mv_count), 32'd0);

        // colour white, then tile without digits
        clr_counts();
        send_str("-W\n@+\n");
        chk("dir_white",   32'(color),    32'd0);
        chk("dir_nodig_fe", 32'(fe_count), 32'd1);

        // reset mid-frame
        clr_counts();
        send_str("C5");
        do_reset();
        send_str("D7+\n");
        chk("dir_rst_mv",  32'(mv_count), 32'd1);
        chk("dir_rst_out", 32'(move_out), 32'({2'd0, 10'd7, 10'd4}));

        // randomized frame stream
        for (int f = 0; f < 300; f++) begin
            q.delete();
            kind = int'($urandom_range(0, 9));
            if (kind <= 1) begin
                q.push_back("-");
                q.push_back($urandom_range(0, 1) ? 8'h42 : 8'h57);
                if ($urandom_range(0, 3) == 0) q.push_back(8'h0D);
                q.push_back(8'h0A);
            end else if (kind <= 6) begin
                gen_move(q);
            end else if (kind == 7) begin
                gen_move(q);
                pos = int'($urandom_range(0, q.size() - 2));
                q[pos] = 8'($urandom_range(32, 126));
            end else if (kind == 8) begin
                for (int k = 0; k < int'($urandom_range(1, 5)); k++)
                    q.push_back(8'($urandom_range(10, 126)));
                q.push_back(8'h0A);
            end else begin
                gen_move(q);
                pos = int'($urandom_range(1, q.size() - 1));
                while (q.size() > pos) void'(q.pop_back());
                q.push_back(8'h0A);
            end
            foreach (q[k]) begin
                step(1'b1, q[k]);
                if ($urandom_range(0, 3) == 0) step(1'b0, 8'($urandom));
            end
        end
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/move_rx_parser.md
MOVE_RX_PARSER -- requirements
Module: move_rx_parser

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; all state lives in the clock domain.
REQ-002 SHALL provide port clock, input, 1 bit: rising-edge clock.
REQ-003 SHALL provide port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL provide port rx_data, input, 8 bits: ASCII byte from the UART receiver.
REQ-005 SHALL provide port rx_valid, input, 1 bit: one-cycle strobe; rx_data is valid in that cycle.
REQ-006 SHALL provide port move_out, output, 22 bits: [21:20] tile code, [19:10] row, [9:0] column.
REQ-007 SHALL provide port move_valid, output, 1 bit: one-cycle pulse when move_out is new.
REQ-008 SHALL provide port color, output, 1 bit: 0 = white, 1 = black.
REQ-009 SHALL provide port color_valid, output, 1 bit: one-cycle pulse when color is new.
REQ-010 SHALL provide port frame_err, output, 1 bit: one-cycle pulse when a frame is rejected.

Function
REQ-011 SHALL parse newline-terminated (0x0A) frames of two kinds:
- colour frames: "-W" or "-B";
- move frames: column letters, then row digits, then one tile character.
REQ-012 SHALL implement these states: IDLE, COLOR, COL, ROW, TILE, EOL, DISCARD.
REQ-013 SHALL advance state only in cycles with rx_valid=1; bytes are consumed one per strobe.
REQ-014 IDLE transitions:
- '-' -> COLOR;
- '@' -> set col=0, -> ROW;
- 'A'..'Z' -> set col=code-0x40, -> COL;
- 0x0A or 0x0D -> stay in IDLE, no output;
- any other byte -> DISCARD.
REQ-015 COLOR: 'W' latches pending colour 0 and 'B' latches 1, then -> EOL; any other byte -> DISCARD.
REQ-016 COL: each further 'A'..'Z' updates col = col*26 + (code-0x40); a digit starts the row and -> ROW; any other byte -> DISCARD.
REQ-017 COL SHALL go to DISCARD if col would exceed 1023.
REQ-018 ROW: each digit updates row = row*10 + digit.
REQ-019 ROW: a tile character '+', '/' or '\' latches tile code 0, 1 or 2 respectively and -> EOL.
REQ-020 ROW SHALL go to DISCARD if row would exceed 1023, if no digit has been received before the tile character, or on any other byte.
REQ-021 SHALL compute the col and row accumulators with at least 15 bits internally; overflow is checked before truncation to 10 bits.
REQ-022 EOL: 0x0D is ignored. On 0x0A, the next cycle pulses move_valid (move frame) or color_valid (colour frame), then -> IDLE. Any other byte -> DISCARD.
REQ-023 move_out and color SHALL update in the same cycle as their valid pulse and hold their value until the next valid frame.
REQ-024 DISCARD: on entry, frame_err pulses for one cycle (the cycle after the offending byte). All bytes are dropped until 0x0A, then -> IDLE with no further pulse.
REQ-025 SHALL NOT pulse frame_err again for the bytes that follow a rejected byte within the same frame.
REQ-026 Latency from the strobe carrying the terminating 0x0A to the valid pulse SHALL be exactly 1 cycle.
REQ-027 SHALL accept back-to-back frames, i.e. rx_valid on consecutive cycles, with no lost bytes.
REQ-028 move_valid, color_valid and frame_err SHALL be mutually exclusive in any cycle.
REQ-029 A new frame's first byte arriving in the same cycle as a valid pulse SHALL be processed normally.

Reset
REQ-030 Asserting reset SHALL immediately force: state=IDLE, move_out=0, color=0, all pulses=0, accumulators=0.
REQ-031 A reset asserted mid-frame SHALL discard the partial frame with no output pulse.
REQ-032 After reset deassertion the first accepted byte SHALL be treated as the start of a frame.

Verification
REQ-033 Byte stream "-B\n" -> color_valid pulse 1 cycle after '\n', color=1.
REQ-034 Byte stream "@0/\n" -> move_valid pulse, move_out = {2'd1, 10'd0, 10'd0}.
REQ-035 Byte stream "AB12\\\n" (tile character is backslash) -> move_valid pulse, move_out = {2'd2, 10'd12, 10'd28}.
REQ-036 Byte stream "A1X\n" then "B3+\n" -> one frame_err pulse after 'X', then move_valid with {2'd0, 10'd3, 10'd2}.
REQ-037 Byte stream "A1024+\n" -> frame_err pulse after the last digit, and no move_valid pulse.
REQ-038 Stimulus "C5" followed by reset asserted for 2 cycles, then "D7+\n" -> exactly one move_valid pulse, with {2'd0, 10'd7, 10'd4}.
